// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
//   Shared definitions for the 5-stage MIPS pipeline hazard controller:
//   register-number width, the zero register, forwarding-select codes,
//   memory-wait FSM state codes, the shadow slot record and the
//   register-match helper used by hazard detection and forwarding.
package mips_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // EXE operand source selects
    localparam int FWD_W = 2;
    localparam logic [FWD_W-1:0] FWD_NONE = 2'b00;  // register file
    localparam logic [FWD_W-1:0] FWD_MEM  = 2'b01;  // result held in MEM
    localparam logic [FWD_W-1:0] FWD_WB   = 2'b10;  // result held in WB

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } wait_state_e;

    // Shadow copy of one in-flight instruction. All-zero is a bubble.
    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic [REG_W-1:0] src1;
        logic [REG_W-1:0] src2;
        logic             two_src;
        logic             wb_en;
        logic             mem_r_en;
        logic             mem_w_en;
    } slot_t;

    // True when 'slot' will write register 'src'. r0 is hardwired, never a hazard.
    function automatic logic slot_match(input logic [REG_W-1:0] src, input slot_t slot);
        return slot.wb_en && (slot.dest == src) && (src != REG_ZERO);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_mem_wait.sv
// mem_wait_fsm
//   Freezes the whole pipeline while a load/store sits in MEM waiting for
//   the SRAM. An access occupies MEM for MEM_WAIT cycles: MEM_WAIT-1 frozen
//   cycles followed by one advance cycle (DONE) in which the access leaves.
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous reset, active-high (aborts an access in progress)
//   mem_op in   the MEM slot holds a load or store
//   freeze out  hold every stage register
//   state  out  current FSM state, for observation
module mem_wait_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_op,
    output logic        freeze,
    output wait_state_e state
);

    localparam int CNT_W = $clog2(MEM_WAIT) + 1;
    localparam bit WAIT_EN   = (MEM_WAIT > 1);
    localparam bit LONG_WAIT = (MEM_WAIT > 2);
    // The IDLE detection cycle is already the first frozen cycle, so BUSY
    // covers the remaining MEM_WAIT-2 cycles (count runs down to zero).
    localparam logic [CNT_W-1:0] CNT_LOAD = LONG_WAIT ? CNT_W'(MEM_WAIT - 3) : '0;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                WAIT_IDLE: begin
                    if (mem_op && WAIT_EN) begin
                        cnt   <= CNT_LOAD;
                        state <= LONG_WAIT ? WAIT_BUSY : WAIT_DONE;
                    end
                end
                WAIT_BUSY: begin
                    if (cnt == '0) state <= WAIT_DONE;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                // The access leaves MEM this cycle; ignoring mem_op here keeps
                // the same access from being counted twice.
                WAIT_DONE: state <= WAIT_IDLE;
                default:   state <= WAIT_IDLE;
            endcase
        end
    end

    // Combinational so the stage registers hold on the very edge after the
    // access lands in MEM.
    assign freeze = (state == WAIT_BUSY) || ((state == WAIT_IDLE) && mem_op && WAIT_EN);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard sequencer for the 5-stage MIPS pipeline. Keeps its own shadow
//   slots for the instructions in EXE, MEM and WB and from them derives
//   load-use / RAW stalls, branch flush, EXE forwarding selects and the
//   SRAM wait-state freeze.
// Parameters
//   MEM_WAIT  cycles a load/store occupies MEM (1 = no freeze)
//   FW_EN     1 = forwarding, stall only on load-use; 0 = stall on any RAW
// Ports
//   clk, rst                 clock / synchronous active-high reset
//   id_src1, id_src2         ID source registers (src2 valid with id_two_src)
//   id_dest, id_wb_en        ID destination and register-write enable
//   id_mem_r_en, id_mem_w_en ID instruction is a load / store
//   br_taken                 branch resolved taken in ID
//   pc_freeze, if_id_freeze  hold PC and IF/ID
//   if_id_flush              load NOP into IF/ID
//   id_exe_bubble            load NOP into ID/EXE
//   pipe_freeze              hold every stage register
//   fwd_sel_a, fwd_sel_b     EXE operand source selects
module pipeline_hazard_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 5,
    parameter int FW_EN    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             id_mem_w_en,
    input  logic             br_taken,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_exe_bubble,
    output logic             pipe_freeze,
    output logic [FWD_W-1:0] fwd_sel_a,
    output logic [FWD_W-1:0] fwd_sel_b
);

    slot_t       id_slot;
    slot_t       exe_slot;
    slot_t       mem_slot;
    slot_t       wb_slot;
    logic        exe_hit;
    logic        mem_hit;
    logic        hazard_stall;
    logic        mem_op;
    wait_state_e mem_wait_state;

    assign id_slot = '{dest:     id_dest,
                       src1:     id_src1,
                       src2:     id_src2,
                       two_src:  id_two_src,
                       wb_en:    id_wb_en,
                       mem_r_en: id_mem_r_en,
                       mem_w_en: id_mem_w_en};

    // ---------------- slot shifting ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            exe_slot <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
        end else if (!pipe_freeze) begin
            wb_slot  <= mem_slot;
            mem_slot <= exe_slot;
            exe_slot <= hazard_stall ? '0 : id_slot;
        end
    end

    // ---------------- hazard detection ----------------
    // The register file writes before it reads, so WB never causes a stall.
    always_comb begin
        exe_hit = slot_match(id_src1, exe_slot) ||
                  (id_two_src && slot_match(id_src2, exe_slot));
        mem_hit = slot_match(id_src1, mem_slot) ||
                  (id_two_src && slot_match(id_src2, mem_slot));
        if (FW_EN != 0) hazard_stall = exe_hit && exe_slot.mem_r_en;
        else            hazard_stall = exe_hit || mem_hit;
    end

    // ---------------- SRAM wait ----------------
    assign mem_op = mem_slot.mem_r_en || mem_slot.mem_w_en;

    mem_wait_fsm #(
        .MEM_WAIT (MEM_WAIT)
    ) u_mem_wait (
        .clk    (clk),
        .rst    (rst),
        .mem_op (mem_op),
        .freeze (pipe_freeze),
        .state  (mem_wait_state)
    );

    // ---------------- pipeline control ----------------
    // Freeze dominates: nothing moves, so no bubble or flush may be injected.
    // A branch resolved while stalled used stale operands and is re-resolved.
    assign pc_freeze     = hazard_stall || pipe_freeze;
    assign if_id_freeze  = hazard_stall || pipe_freeze;
    assign id_exe_bubble = hazard_stall && !pipe_freeze;
    assign if_id_flush   = br_taken && !hazard_stall && !pipe_freeze;

    // ---------------- forwarding ----------------
    // Purely from slots, so the selects stay constant while frozen.
    always_comb begin
        fwd_sel_a = FWD_NONE;
        fwd_sel_b = FWD_NONE;
        if (FW_EN != 0) begin
            if (slot_match(exe_slot.src1, mem_slot))     fwd_sel_a = FWD_MEM;
            else if (slot_match(exe_slot.src1, wb_slot)) fwd_sel_a = FWD_WB;
            if (exe_slot.two_src) begin
                if (slot_match(exe_slot.src2, mem_slot))     fwd_sel_b = FWD_MEM;
                else if (slot_match(exe_slot.src2, wb_slot)) fwd_sel_b = FWD_WB;
            end
        end
    end

    // Slot fields kept for observability but not needed by the control logic.
    logic slot_unused;
    assign slot_unused = ^{exe_slot.mem_w_en, mem_slot.src1, mem_slot.src2,
                           mem_slot.two_src, wb_slot.src1, wb_slot.src2,
                           wb_slot.two_src, wb_slot.mem_r_en, wb_slot.mem_w_en,
                           mem_wait_state};

endmodule
